mem_arbiter: RTL and testbench

- Arbitrates the single unified memory port of the multicycle core between two requesters:
  - the core datapath (instruction fetch and load/store);
  - an external port used by the boot loader or debug host.
- Registers each granted access, sequences it through a fixed-latency memory and returns read data with a one-cycle completion pulse.
- Drives a stall to the core so the core's control FSM holds its state while the memory is busy or owned by the external port.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_rr.sv | 21 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter of the multicycle core.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    CORE = 1'b0,
    EXT  = 1'b1
  } owner_t;

  // Value loaded into the wait counter so WAIT lasts exactly lat cycles.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   i_core_req,
  input  logic   i_ext_req,
  input  owner_t i_last_grant,
  output owner_t o_grant,
  output logic   o_valid
);

  always_comb begin
    o_valid = i_core_req | i_ext_req;
    o_grant = CORE;
    if (i_core_req && i_ext_req)
      o_grant = (i_last_grant == CORE) ? EXT : CORE;
    else if (i_ext_req)
      o_grant = EXT;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core and external port onto one fixed-latency memory port.
// Optional MEM_ARB_STALL_CNT_EN adds a saturating count of core stall cycles caused by EXT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
`ifdef MEM_ARB_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  owner_t            r_owner;
  owner_t            r_last_grant;
  owner_t            w_gnt;
  logic              w_gnt_vld;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_ext_rdata;

  mem_arb_rr u_rr (
    .i_core_req  (core_req),
    .i_ext_req   (ext_req),
    .i_last_grant(r_last_grant),
    .o_grant     (w_gnt),
    .o_valid     (w_gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    mem_en       = 1'b0;
    core_ready   = 1'b0;
    ext_ack      = 1'b0;
    case (r_state)
      IDLE:  if (w_gnt_vld) w_next_state = ISSUE;
      ISSUE: begin
        mem_en       = 1'b1;
        w_next_state = WAIT;
      end
      WAIT:  if (r_cnt == '0) w_next_state = DONE;
      DONE: begin
        core_ready   = (r_owner == CORE);
        ext_ack      = (r_owner == EXT);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= CORE;
      r_last_grant <= EXT;
      r_cnt        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_ext_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_vld) begin
          r_owner      <= w_gnt;
          r_last_grant <= w_gnt;
          r_mem_we     <= (w_gnt == EXT) ? ext_we    : core_we;
          r_mem_addr   <= (w_gnt == EXT) ? ext_addr  : core_addr;
          r_mem_wdata  <= (w_gnt == EXT) ? ext_wdata : core_wdata;
        end
        ISSUE: r_cnt <= LAT_LOAD;
        WAIT: begin
          if (r_cnt == '0) begin
            // Writes leave both read-data registers untouched.
            if (!r_mem_we) begin
              if (r_owner == CORE) r_core_rdata <= mem_rdata;
              else                 r_ext_rdata  <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_stall = core_req & ~core_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rdata = r_core_rdata;
  assign ext_rdata  = r_ext_rdata;

`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cycles;
  logic        w_ext_owned;

  // In IDLE the pending grant decides ownership; otherwise the latched owner.
  assign w_ext_owned = (r_state == IDLE) ? (w_gnt_vld && (w_gnt == EXT))
                                         : (r_owner == EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (core_stall && w_ext_owned && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard and multi-cycle corner sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, core_ready, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        ext_req, ext_we, ext_ack;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, rd1;
  logic        c3_req, c3_ready, c3_stall, e3_ack, en3, we3;
  logic [31:0] c3_addr, c3_rdata, e3_rdata, addr3, wdata3, rd3;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat1, pl_dat3;
`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_cycles, stall3;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
`ifdef MEM_ARB_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(rd1)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .core_req(c3_req), .core_we(1'b0), .core_addr(c3_addr), .core_wdata(32'h0),
    .core_rdata(c3_rdata), .core_ready(c3_ready), .core_stall(c3_stall),
    .ext_req(1'b0), .ext_we(1'b0), .ext_addr(32'h0), .ext_wdata(32'h0),
    .ext_rdata(e3_rdata), .ext_ack(e3_ack),
`ifdef MEM_ARB_STALL_CNT_EN
    .stall_cycles(stall3),
`endif
    .mem_en(en3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3),
    .mem_rdata(rd3)
  );

  // Memory models; read data outside the valid window is poisoned.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p3_0, p3_1, p3_2;
  assign rd3 = p3_2;

  always @(posedge clk) begin
    if (pl_en) mem1[pl_idx] <= pl_dat1;
    else if (mem_en && mem_we) mem1[mem_addr[9:2]] <= mem_wdata;
    rd1 <= (mem_en && !mem_we) ? mem1[mem_addr[9:2]] : 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    if (pl_en) mem3[pl_idx] <= pl_dat3;
    else if (en3 && we3) mem3[addr3[9:2]] <= wdata3;
    p3_0 <= (en3 && !we3) ? mem3[addr3[9:2]] : 32'hBAD0BAD0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          is_ext;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          is_ext;
    logic [31:0] core_rd;
    logic [31:0] ext_rd;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] m_core_rd, m_ext_rd;

  task automatic sb_push(input bit is_ext, input bit we, input logic [31:0] exp_rd);
    sb_t it;
    if (!we) begin
      if (is_ext) m_ext_rd = exp_rd;
      else        m_core_rd = exp_rd;
    end
    it.is_ext  = is_ext;
    it.core_rd = m_core_rd;
    it.ext_rd  = m_ext_rd;
    sb_q.push_back(it);
  endtask

  always @(negedge clk) begin
    if (rst_n && (core_ready || ext_ack)) begin
      sb_t it;
      if (core_ready && ext_ack)
        chk("both acks together", 32'(core_ready & ext_ack), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected ack", 32'd1, 32'd0);
      end else begin
        it = sb_q.pop_front();
        chk("sb ack owner", 32'(ext_ack), 32'(it.is_ext));
        chk("sb core_rdata", core_rdata, it.core_rd);
        chk("sb ext_rdata", ext_rdata, it.ext_rd);
      end
    end
  end

  task automatic run_txn(input vec_t v, input string nm);
    bit got = 0;
    @(posedge clk); #1;
    if (v.is_ext) begin
      ext_req = 1'b1; ext_we = v.we; ext_addr = v.addr; ext_wdata = v.wdata;
    end else begin
      core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata;
    end
    sb_push(v.is_ext, v.we, v.exp_rd);
    @(negedge clk);
    chk({nm, " stall N"}, 32'(core_stall), 32'(!v.is_ext));
    chk({nm, " mem_en N"}, 32'(mem_en), 32'd0);
    @(negedge clk);
    chk({nm, " mem_en N+1"}, 32'(mem_en), 32'd1);
    chk({nm, " mem_we"}, 32'(mem_we), 32'(v.we));
    chk({nm, " mem_addr"}, mem_addr, v.addr);
    if (v.we) chk({nm, " mem_wdata"}, mem_wdata, v.wdata);
    for (int c = 2; c < 40 && !got; c++) begin
      @(negedge clk);
      if (core_ready || ext_ack) begin
        got = 1;
        chk({nm, " ack latency"}, 32'(c), 32'd3);
        if (!v.is_ext) chk({nm, " stall at ack"}, 32'(core_stall), 32'd0);
      end else begin
        if (!v.is_ext) chk({nm, " stall in wait"}, 32'(core_stall), 32'd1);
        chk({nm, " mem_en in wait"}, 32'(mem_en), 32'd0);
      end
    end
    if (!got) chk({nm, " ack timeout"}, 32'd0, 32'd1);
    core_req = 1'b0;
    ext_req  = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_core, n_ext, n_en, grants, ack_c, en_c, en_cyc, n_acks;
    bit hit;
    logic [31:0] exp_addr;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h00001234, 32'h00000000};
    vecs[2] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'h00001234};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h00001234};
    vecs[5] = '{1'b1, 1'b1, 32'h10, 32'h55AA55AA, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h55AA55AA};
    vecs[7] = '{1'b1, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D};

    rst_n = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    c3_req = 0; c3_addr = 0;
    m_core_rd = 0; m_ext_rd = 0;
    pl_en = 1'b1; pl_idx = 8'd4; pl_dat1 = 32'hDEADBEEF; pl_dat3 = 32'h33330001;
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst core_rdata", core_rdata, 32'd0);
    chk("rst ext_rdata", ext_rdata, 32'd0);
    chk("rst core_ready", 32'(core_ready), 32'd0);
    chk("rst ext_ack", 32'(ext_ack), 32'd0);
    chk("rst core_stall", 32'(core_stall), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-WAIT: abandoned access, outputs cleared at once.
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort core_rdata cleared", core_rdata, 32'd0);
    chk("abort ext_rdata cleared", ext_rdata, 32'd0);
    chk("abort mem_addr cleared", mem_addr, 32'd0);
    chk("abort core_ready", 32'(core_ready), 32'd0);
    core_req = 1'b0;
    m_core_rd = 0; m_ext_rd = 0;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (core_ready || ext_ack) n_acks++;
    end
    chk("no ack for aborted access", 32'(n_acks), 32'd0);

    // Both requesters held: round robin starting with the core.
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    ext_req  = 1'b1; ext_we  = 1'b0; ext_addr  = 32'h40;
    grants = 0; n_core = 0; n_ext = 0; n_en = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (core_ready) n_core++;
      if (ext_ack) n_ext++;
      if (mem_en) begin
        n_en++;
        if (grants < 4) begin
          exp_addr = grants[0] ? 32'h40 : 32'h10;
          chk($sformatf("rr grant%0d addr", grants), mem_addr, exp_addr);
          if (grants[0]) sb_push(1'b1, 1'b0, 32'h00001234);
          else           sb_push(1'b0, 1'b0, 32'h55AA55AA);
          grants++;
          if (grants == 4) begin
            core_req = 1'b0;
            ext_req  = 1'b0;
          end
        end
      end
    end
    chk("rr grants", 32'(grants), 32'd4);
    chk("rr mem_en pulses", 32'(n_en), 32'd4);
    chk("rr core acks", 32'(n_core), 32'd2);
    chk("rr ext acks", 32'(n_ext), 32'd2);

    // MEM_LAT=3 instance.
    @(posedge clk); #1;
    c3_req = 1'b1; c3_addr = 32'h10;
    ack_c = -1; en_c = 0; en_cyc = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (en3) begin
        en_c++;
        en_cyc = c;
      end
      if (c3_ready && ack_c < 0) begin
        ack_c = c;
        chk("lat3 rdata", c3_rdata, 32'h33330001);
        c3_req = 1'b0;
      end
    end
    c3_req = 1'b0;
    chk("lat3 ack latency", 32'(ack_c), 32'd5);
    chk("lat3 mem_en count", 32'(en_c), 32'd1);
    chk("lat3 mem_en cycle", 32'(en_cyc), 32'd1);

`ifdef MEM_ARB_STALL_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    m_core_rd = 0; m_ext_rd = 0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("stall cnt reset", stall_cycles, 32'd0);
    run_txn('{1'b0, 1'b0, 32'h10, 32'h0, 32'h55AA55AA}, "pre core");
    chk("stall cnt after core", stall_cycles, 32'd0);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    ext_req  = 1'b1; ext_we  = 1'b0; ext_addr  = 32'h80;
    sb_push(1'b1, 1'b0, 32'hCAFEF00D);
    sb_push(1'b0, 1'b0, 32'h00001234);
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (ext_ack) ext_req = 1'b0;
      if (mem_en && mem_addr == 32'h40) chk("stall cnt at core grant", stall_cycles, 32'd4);
      if (core_ready) begin
        core_req = 1'b0;
        hit = 1;
      end
    end
    if (!hit) chk("stall seq timeout", 32'd0, 32'd1);
    chk("stall cnt final", stall_cycles, 32'd4);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
